// File: rtl/venmac_pkg.sv
// Shared types and constants for the parametrised vending controller.
// Holds the FSM state encoding, the coin codes, the change denominations and the coin-value lookup.
package venmac_pkg;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        COLLECT = 2'd1,
        VEND    = 2'd2,
        CHANGE  = 2'd3
    } state_t;

    localparam logic [1:0] COIN_10  = 2'd0;
    localparam logic [1:0] COIN_50  = 2'd1;
    localparam logic [1:0] COIN_100 = 2'd2;
    localparam logic [1:0] COIN_BAD = 2'd3;

    localparam int unsigned CHG_10_VAL = 10;
    localparam int unsigned CHG_50_VAL = 50;

    function automatic logic [7:0] coin_value(input logic [1:0] sel);
        case (sel)
            COIN_10:  coin_value = 8'd10;
            COIN_50:  coin_value = 8'd50;
            COIN_100: coin_value = 8'd100;
            default:  coin_value = 8'd0;
        endcase
    endfunction

endpackage

// File: rtl/venmac_param_if.sv
// Coin-acceptor / dispenser side bundle of the vending controller.
// master drives the coin and ack strobes, slave (the controller) drives the registered outputs.
interface venmac_param_if #(
    parameter int CREDIT_W = 8
);
    logic                coin_vld;
    logic [1:0]          coin_sel;
    logic                cancel;
    logic                vend_ack;
    logic                vend_req;
    logic [CREDIT_W-1:0] credit;
    logic                chg_10;
    logic                chg_50;
    logic                coin_rej;
    logic                busy;

    modport master (
        output coin_vld, coin_sel, cancel, vend_ack,
        input  vend_req, credit, chg_10, chg_50, coin_rej, busy
    );

    modport slave (
        input  coin_vld, coin_sel, cancel, vend_ack,
        output vend_req, credit, chg_10, chg_50, coin_rej, busy
    );
endinterface

// File: rtl/venmac_chg_unit.sv
// Change picker: chooses the next coin to eject from the current credit (largest first).
// Latency: purely combinational, 0 cycles.
// Backpressure: none; the caller decides when the pick is consumed.
module venmac_chg_unit
    import venmac_pkg::*;
#(
    parameter int CREDIT_W = 8
) (
    input  logic [CREDIT_W-1:0] credit,
    output logic                chg_50,
    output logic                chg_10,
    output logic [CREDIT_W-1:0] credit_nxt
);

    always_comb begin
        chg_50     = 1'b0;
        chg_10     = 1'b0;
        credit_nxt = credit;
        if (credit >= CREDIT_W'(CHG_50_VAL)) begin
            chg_50     = 1'b1;
            credit_nxt = credit - CREDIT_W'(CHG_50_VAL);
        end else if (credit != '0) begin
            chg_10     = 1'b1;
            credit_nxt = credit - CREDIT_W'(CHG_10_VAL);
        end
    end

endmodule

// File: rtl/venmac_param.sv
// Vending controller: collects coins, vends at PRICE, pays change/refunds as 50/10 pulses (VENMAC_TIMEOUT_EN adds a vend_ack timeout).
// Latency: every output registered; coin reaching PRICE raises vend_req on the same edge it is credited.
// Backpressure: coins arriving while in VEND/CHANGE are returned via coin_rej; vend_req holds until vend_ack.
module venmac_param
    import venmac_pkg::*;
#(
    parameter int PRICE      = 30,
    parameter int CREDIT_W   = 8,
    parameter int MAX_CREDIT = 100,
    parameter int TIMEOUT    = 16
) (
    input logic           clk,
    input logic           rst,
    venmac_param_if.slave bus
);

    localparam int SW = CREDIT_W + 1;

    if (PRICE <= 0 || (PRICE % 10) != 0 || PRICE > MAX_CREDIT ||
        MAX_CREDIT >= (1 << CREDIT_W) || TIMEOUT < 1) begin : g_bad_param
        $error("venmac_param: illegal parameter combination");
    end

    state_t              state;
    logic [CREDIT_W-1:0] credit_q;
    logic                vend_req_q;
    logic                chg_10_q;
    logic                chg_50_q;
    logic                coin_rej_q;
    logic                busy_q;

    // One bit wider than credit so the MAX_CREDIT compare cannot wrap.
    logic [SW-1:0]       sum;
    logic                coin_ok;
    logic [CREDIT_W-1:0] vend_left;
    logic                pick_50;
    logic                pick_10;
    logic [CREDIT_W-1:0] chg_left;

    assign sum       = {1'b0, credit_q} + SW'(coin_value(bus.coin_sel));
    assign coin_ok   = (bus.coin_sel != COIN_BAD) && (sum <= SW'(MAX_CREDIT));
    assign vend_left = credit_q - CREDIT_W'(PRICE);

    venmac_chg_unit #(
        .CREDIT_W (CREDIT_W)
    ) u_chg (
        .credit     (credit_q),
        .chg_50     (pick_50),
        .chg_10     (pick_10),
        .credit_nxt (chg_left)
    );

`ifdef VENMAC_TIMEOUT_EN
    localparam int TW = $clog2(TIMEOUT + 1);
    logic [TW-1:0] vend_cnt;
    logic          vend_to;
    // vend_cnt holds the VEND cycles already completed before the current one.
    assign vend_to = (vend_cnt == TW'(TIMEOUT - 1));
`endif

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= IDLE;
            credit_q   <= '0;
            vend_req_q <= 1'b0;
            chg_10_q   <= 1'b0;
            chg_50_q   <= 1'b0;
            coin_rej_q <= 1'b0;
            busy_q     <= 1'b0;
`ifdef VENMAC_TIMEOUT_EN
            vend_cnt   <= '0;
`endif
        end else begin
            chg_10_q   <= 1'b0;
            chg_50_q   <= 1'b0;
            coin_rej_q <= 1'b0;
`ifdef VENMAC_TIMEOUT_EN
            vend_cnt   <= (state == VEND) ? vend_cnt + 1'b1 : '0;
`endif
            case (state)
                IDLE, COLLECT: begin
                    if (bus.cancel) begin
                        coin_rej_q <= bus.coin_vld;
                        if (credit_q != '0) begin
                            state  <= CHANGE;
                            busy_q <= 1'b1;
                        end
                    end else if (bus.coin_vld) begin
                        if (coin_ok) begin
                            credit_q <= sum[CREDIT_W-1:0];
                            if (sum >= SW'(PRICE)) begin
                                state      <= VEND;
                                vend_req_q <= 1'b1;
                                busy_q     <= 1'b1;
                            end else begin
                                state <= COLLECT;
                            end
                        end else begin
                            coin_rej_q <= 1'b1;
                        end
                    end
                end

                VEND: begin
                    coin_rej_q <= bus.coin_vld;
                    if (bus.vend_ack) begin
                        credit_q   <= vend_left;
                        vend_req_q <= 1'b0;
                        if (vend_left != '0) begin
                            state <= CHANGE;
                        end else begin
                            state  <= IDLE;
                            busy_q <= 1'b0;
                        end
                    end
`ifdef VENMAC_TIMEOUT_EN
                    else if (vend_to) begin
                        vend_req_q <= 1'b0;
                        state      <= CHANGE;
                    end
`endif
                end

                CHANGE: begin
                    coin_rej_q <= bus.coin_vld;
                    chg_50_q   <= pick_50;
                    chg_10_q   <= pick_10;
                    credit_q   <= chg_left;
                    if (chg_left == '0) begin
                        state  <= IDLE;
                        busy_q <= 1'b0;
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

    assign bus.vend_req = vend_req_q;
    assign bus.credit   = credit_q;
    assign bus.chg_10   = chg_10_q;
    assign bus.chg_50   = chg_50_q;
    assign bus.coin_rej = coin_rej_q;
    assign bus.busy     = busy_q;

endmodule

// File: tb/tb_venmac_param.sv
// Bench for venmac_param: directed sequences with literal expectations, then random stimulus,
// all outputs compared every cycle against a credit/refund-queue model.
module tb_venmac_param;

    localparam int PRICE = 30;
    localparam int CW    = 8;
    localparam int MAXC  = 100;
    localparam int TO    = 4;

`ifdef VENMAC_TIMEOUT_EN
    localparam bit TO_EN = 1'b1;
`else
    localparam bit TO_EN = 1'b0;
`endif

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    venmac_param_if #(.CREDIT_W(CW)) vif();

    venmac_param #(
        .PRICE      (PRICE),
        .CREDIT_W   (CW),
        .MAX_CREDIT (MAXC),
        .TIMEOUT    (TO)
    ) dut (
        .clk (clk),
        .rst (rst),
        .bus (vif.slave)
    );

    int n_vec = 0;
    int n_bad = 0;

    task automatic chk(input string nm, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s at %0t: got %0d, expected %0d", nm, $time, act, exp);
        end
    endtask

    // ---------------- behavioural model ----------------
    int m_credit = 0;
    bit m_vend   = 1'b0;
    int m_wait   = 0;
    int m_q[$];          // coins still to be paid out, in ejection order
    bit e_rej = 1'b0, e_c10 = 1'b0, e_c50 = 1'b0;

    function automatic int value_of(input logic [1:0] sel);
        case (sel)
            2'd0:    return 10;
            2'd1:    return 50;
            2'd2:    return 100;
            default: return 0;
        endcase
    endfunction

    function automatic void refund(input int amount);
        int a = amount;
        while (a >= 50) begin m_q.push_back(50); a -= 50; end
        while (a > 0)   begin m_q.push_back(10); a -= 10; end
    endfunction

    function automatic void model_step();
        int coin;
        int v;
        e_rej = 1'b0; e_c10 = 1'b0; e_c50 = 1'b0;
        if (!rst) begin
            m_credit = 0; m_vend = 1'b0; m_wait = 0; m_q.delete();
        end else if (m_q.size() > 0) begin
            coin = m_q.pop_front();
            m_credit -= coin;
            e_c50 = (coin == 50);
            e_c10 = (coin == 10);
            e_rej = vif.coin_vld;
        end else if (m_vend) begin
            e_rej = vif.coin_vld;
            if (vif.vend_ack) begin
                m_credit -= PRICE;
                m_vend = 1'b0;
                refund(m_credit);
            end else if (TO_EN) begin
                m_wait++;
                if (m_wait == TO) begin
                    m_vend = 1'b0;
                    refund(m_credit);
                end
            end
        end else if (vif.cancel) begin
            e_rej = vif.coin_vld;
            if (m_credit > 0) refund(m_credit);
        end else if (vif.coin_vld) begin
            v = value_of(vif.coin_sel);
            if (vif.coin_sel == 2'd3 || m_credit + v > MAXC) begin
                e_rej = 1'b1;
            end else begin
                m_credit += v;
                if (m_credit >= PRICE) begin
                    m_vend = 1'b1;
                    m_wait = 0;
                end
            end
        end
    endfunction

    // Single compare process: model advances on each edge, DUT sampled 1 time unit later.
    always @(posedge clk) begin
        model_step();
        #1;
        chk("credit",   int'(vif.credit),   m_credit);
        chk("vend_req", int'(vif.vend_req), int'(m_vend));
        chk("busy",     int'(vif.busy),     int'(m_vend || (m_q.size() > 0)));
        chk("chg_10",   int'(vif.chg_10),   int'(e_c10));
        chk("chg_50",   int'(vif.chg_50),   int'(e_c50));
        chk("coin_rej", int'(vif.coin_rej), int'(e_rej));
    end

    // ---------------- stimulus ----------------
    task automatic step(input bit cv, input logic [1:0] sel, input bit can,
                        input bit ack, input bit r);
        @(negedge clk);
        vif.coin_vld = cv;
        vif.coin_sel = sel;
        vif.cancel   = can;
        vif.vend_ack = ack;
        rst          = r;
        @(posedge clk);
        #2;
    endtask

    task automatic idle();               step(1'b0, 2'd0, 1'b0, 1'b0, 1'b1); endtask
    task automatic coin(input logic [1:0] s); step(1'b1, s, 1'b0, 1'b0, 1'b1); endtask
    task automatic ack();                step(1'b0, 2'd0, 1'b0, 1'b1, 1'b1); endtask
    task automatic cancel();             step(1'b0, 2'd0, 1'b1, 1'b0, 1'b1); endtask

    task automatic drain();
        int k = 0;
        while (vif.busy && k < 20) begin
            if (vif.vend_req) ack(); else idle();
            k++;
        end
        chk("drain_bound", int'(vif.busy), 0);
    endtask

    initial begin
        vif.coin_vld = 1'b0;
        vif.coin_sel = 2'd0;
        vif.cancel   = 1'b0;
        vif.vend_ack = 1'b0;
        rst          = 1'b0;

        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("lit_rst_credit", int'(vif.credit), 0);
        chk("lit_rst_vreq",   int'(vif.vend_req), 0);
        chk("lit_rst_busy",   int'(vif.busy), 0);

        // three 10s reach PRICE, exact vend leaves no change
        coin(2'd0); chk("lit_t1_c10", int'(vif.credit), 10);
        coin(2'd0); chk("lit_t1_c20", int'(vif.credit), 20);
        coin(2'd0); chk("lit_t1_c30", int'(vif.credit), 30);
        chk("lit_t1_vreq", int'(vif.vend_req), 1);
        chk("lit_t1_busy", int'(vif.busy), 1);
        ack();
        chk("lit_t1_after", int'(vif.credit), 0);
        chk("lit_t1_idle",  int'(vif.busy), 0);
        idle(); chk("lit_t1_nochg", int'(vif.chg_10 | vif.chg_50), 0);

        // 10 + 50 = 60, vend leaves 30 paid as three 10s
        coin(2'd0); coin(2'd1);
        chk("lit_t2_c60", int'(vif.credit), 60);
        chk("lit_t2_vreq", int'(vif.vend_req), 1);
        ack(); chk("lit_t2_rem", int'(vif.credit), 30);
        idle(); chk("lit_t2_p1", int'(vif.chg_10), 1); chk("lit_t2_r20", int'(vif.credit), 20);
        idle(); chk("lit_t2_p2", int'(vif.chg_10), 1); chk("lit_t2_r10", int'(vif.credit), 10);
        idle(); chk("lit_t2_p3", int'(vif.chg_10), 1); chk("lit_t2_r0",  int'(vif.credit), 0);
        chk("lit_t2_busy", int'(vif.busy), 0);

        // cancel refund; cancel with coin rejects the coin
        coin(2'd0); coin(2'd0); cancel();
        chk("lit_t3_vreq", int'(vif.vend_req), 0);
        idle(); chk("lit_t3_p1", int'(vif.chg_10), 1);
        idle(); chk("lit_t3_p2", int'(vif.chg_10), 1); chk("lit_t3_r0", int'(vif.credit), 0);
        coin(2'd0);
        step(1'b1, 2'd1, 1'b1, 1'b0, 1'b1);
        chk("lit_t3_rej", int'(vif.coin_rej), 1);
        chk("lit_t3_keep", int'(vif.credit), 10);
        drain();

        // overflow, invalid code, coin during VEND
        coin(2'd0); coin(2'd0); coin(2'd2);
        chk("lit_t4_ovf_rej", int'(vif.coin_rej), 1);
        chk("lit_t4_ovf_cr", int'(vif.credit), 20);
        coin(2'd3);
        chk("lit_t4_bad_rej", int'(vif.coin_rej), 1);
        coin(2'd0); coin(2'd0);
        chk("lit_t4_vend_rej", int'(vif.coin_rej), 1);
        chk("lit_t4_vend_cr", int'(vif.credit), 30);
        drain();

        // 100 -> 70 change: 50 then 10; reset mid-change
        coin(2'd2); chk("lit_t5_c100", int'(vif.credit), 100);
        ack(); chk("lit_t5_rem", int'(vif.credit), 70);
        idle(); chk("lit_t5_p50", int'(vif.chg_50), 1); chk("lit_t5_r20", int'(vif.credit), 20);
        step(1'b0, 2'd0, 1'b0, 1'b0, 1'b0);
        chk("lit_t5_rst_cr", int'(vif.credit), 0);
        chk("lit_t5_rst_chg", int'(vif.chg_10 | vif.chg_50), 0);
        chk("lit_t5_rst_busy", int'(vif.busy), 0);
        idle();

`ifdef VENMAC_TIMEOUT_EN
        coin(2'd0); coin(2'd0); coin(2'd0);
        idle(); idle(); idle();
        chk("lit_t6_wait", int'(vif.vend_req), 1);
        idle();
        chk("lit_t6_to_vreq", int'(vif.vend_req), 0);
        chk("lit_t6_to_cr", int'(vif.credit), 30);
        chk("lit_t6_to_busy", int'(vif.busy), 1);
        for (int i = 0; i < 3; i++) begin
            idle(); chk("lit_t6_refund", int'(vif.chg_10), 1);
        end
        chk("lit_t6_r0", int'(vif.credit), 0);
        coin(2'd0); coin(2'd0); coin(2'd0);
        idle(); idle(); idle();
        ack();
        chk("lit_t6_ack_cr", int'(vif.credit), 0);
        chk("lit_t6_ack_busy", int'(vif.busy), 0);
`else
        coin(2'd0); coin(2'd0); coin(2'd0);
        for (int i = 0; i < 10; i++) idle();
        chk("lit_t6_hold", int'(vif.vend_req), 1);
        ack();
        chk("lit_t6_ack_cr", int'(vif.credit), 0);
`endif
        idle();

        for (int i = 0; i < 2500; i++) begin
            step($urandom_range(0, 2) == 0,
                 2'($urandom_range(0, 3)),
                 $urandom_range(0, 11) == 0,
                 $urandom_range(0, 4) == 0,
                 $urandom_range(0, 299) != 0);
        end
        drain();
        idle();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, %0d vectors applied", n_vec);
        $fatal(1, "watchdog");
    end

endmodule
